// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types for the pipeline hazard controller: FSM states,
//                forwarding-select encodings and the scoreboard entry record.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int SB_AW = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2
    } state_e;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] rd;
        logic             regwrite;
        logic             memread;
        logic [SB_AW-1:0] rs;
        logic [SB_AW-1:0] rt;
    } sb_entry_t;

    // An entry produces src when it is a live register write to a non-zero rd.
    function automatic logic sb_hit(input sb_entry_t e, input logic [SB_AW-1:0] src);
        return e.valid && e.regwrite && (e.rd != '0) && (e.rd == src);
    endfunction

    function automatic logic src_hazard(input sb_entry_t e,
                                        input logic [SB_AW-1:0] rs, input logic use_rs,
                                        input logic [SB_AW-1:0] rt, input logic use_rt);
        return (use_rs && sb_hit(e, rs)) || (use_rt && sb_hit(e, rt));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_unit
//  Description : Selects the forwarding source for one EX operand by comparing
//                its register against the EX_MEM and MEM_WB scoreboard entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit
    import hazard_pkg::*;
(
    input  logic [SB_AW-1:0] src_i,
    input  sb_entry_t        mem_ent_i,
    input  sb_entry_t        wb_ent_i,
    output logic [1:0]       fwd_o
);

    // The younger result in EX_MEM wins over the older one in MEM_WB.
    always_comb begin
        fwd_o = FWD_REG;
        if (sb_hit(mem_ent_i, src_i)) begin
            fwd_o = FWD_EXMEM;
        end else if (sb_hit(wb_ent_i, src_i)) begin
            fwd_o = FWD_MEMWB;
        end
    end

    logic unused_w;
    assign unused_w = ^{mem_ent_i.memread, mem_ent_i.rs, mem_ent_i.rt,
                        wb_ent_i.memread, wb_ent_i.rs, wb_ent_i.rt};

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Hazard/sequencing controller for a 5-stage MIPS pipeline.
//                Optional macro HAZARD_FORWARDING_EN enables EX forwarding and
//                restricts data stalls to load-use.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              branch_taken_i,
    input  logic              mem_stall_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic              ex_mem_write_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    state_e           state_q, state_d;
    sb_entry_t        ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [SB_AW-1:0] rs_w, rt_w, rd_w;
    logic             data_stall_w;
    logic             cnt_inc_w;

    assign rs_w = SB_AW'(id_rs_i);
    assign rt_w = SB_AW'(id_rt_i);
    assign rd_w = SB_AW'(id_rd_i);

`ifdef HAZARD_FORWARDING_EN
    // Only a load in EX cannot be forwarded in time.
    assign data_stall_w = ex_q.memread &&
                          src_hazard(ex_q, rs_w, id_use_rs_i, rt_w, id_use_rt_i);
`else
    assign data_stall_w = src_hazard(ex_q,  rs_w, id_use_rs_i, rt_w, id_use_rt_i) ||
                          src_hazard(mem_q, rs_w, id_use_rs_i, rt_w, id_use_rt_i) ||
                          src_hazard(wb_q,  rs_w, id_use_rs_i, rt_w, id_use_rt_i);
`endif

    always_comb begin
        state_d        = state_q;
        ex_d           = ex_q;
        mem_d          = mem_q;
        wb_d           = wb_q;
        cnt_inc_w      = 1'b0;
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b1;
        ex_mem_write_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            default: begin
                if (mem_stall_i) begin
                    state_d        = FREEZE;
                    id_ex_bubble_o = 1'b0;
                    cnt_inc_w      = 1'b1;
                end else begin
                    state_d        = RUN;
                    ex_mem_write_o = 1'b1;
                    mem_d          = ex_q;
                    wb_d           = mem_q;
                    if (data_stall_w) begin
                        // A pending branch simply waits in ID until the stall clears.
                        ex_d      = '0;
                        cnt_inc_w = 1'b1;
                    end else begin
                        pc_write_o     = 1'b1;
                        if_id_write_o  = 1'b1;
                        id_ex_bubble_o = 1'b0;
                        if_id_flush_o  = branch_taken_i;
                        ex_d = '{valid: 1'b1, rd: rd_w, regwrite: id_regwrite_i,
                                 memread: id_memread_i, rs: rs_w, rt: rt_w};
                    end
                end
            end
        endcase
        stall_cnt_d = (cnt_inc_w && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1)
                                                         : stall_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

`ifdef HAZARD_FORWARDING_EN
    logic [1:0] fwd_a_sel_w, fwd_b_sel_w;

    hazard_fwd_unit u_fwd_a (
        .src_i     (ex_q.rs),
        .mem_ent_i (mem_q),
        .wb_ent_i  (wb_q),
        .fwd_o     (fwd_a_sel_w)
    );

    hazard_fwd_unit u_fwd_b (
        .src_i     (ex_q.rt),
        .mem_ent_i (mem_q),
        .wb_ent_i  (wb_q),
        .fwd_o     (fwd_b_sel_w)
    );

    assign fwd_a_o = (state_q == IDLE) ? FWD_REG : fwd_a_sel_w;
    assign fwd_b_o = (state_q == IDLE) ? FWD_REG : fwd_b_sel_w;
`else
    assign fwd_a_o = FWD_REG;
    assign fwd_b_o = FWD_REG;
`endif

    logic unused_w;
    assign unused_w = ^{ex_q, mem_q, wb_q};

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Directed self-checking bench for pipeline_hazard_ctrl with an
//                instruction-level reference model of the pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int TB_CNT_W = 3;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
`ifdef HAZARD_FORWARDING_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    typedef struct {
        bit v;
        int rs;
        int rt;
        bit urs;
        bit urt;
        int rd;
        bit rw;
        bit mr;
        bit br;
    } ins_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, start, use_rs, use_rt, regwrite, memread, br, mem_stall;
    logic [4:0]          id_rs, id_rt, id_rd;
    logic                pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, ex_mem_write_o;
    logic [1:0]          fwd_a_o, fwd_b_o;
    logic [TB_CNT_W-1:0] stall_cnt_o;

    pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(TB_CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_use_rs_i    (use_rs),
        .id_use_rt_i    (use_rt),
        .id_rd_i        (id_rd),
        .id_regwrite_i  (regwrite),
        .id_memread_i   (memread),
        .branch_taken_i (br),
        .mem_stall_i    (mem_stall),
        .pc_write_o     (pc_write_o),
        .if_id_write_o  (if_id_write_o),
        .if_id_flush_o  (if_id_flush_o),
        .id_ex_bubble_o (id_ex_bubble_o),
        .ex_mem_write_o (ex_mem_write_o),
        .fwd_a_o        (fwd_a_o),
        .fwd_b_o        (fwd_b_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    // Model: instructions in flight past ID, youngest first (EX, MEM, WB).
    ins_t inflight[$];
    ins_t prog[$];
    ins_t cur_id;
    ins_t nop_i;
    bit   m_valid = 0;
    int   m_state = 0;     // 0 idle, 1 running, 2 frozen
    int   m_cnt   = 0;
    bit   m_adv   = 0;
    int   cyc_n, obs_stalls, obs_flush, last_stall, flush_at;
    bit   seen_a01, seen_ab10, seen_fwd;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(int rs, int rt, bit urs, bit urt, int rd, bit rw, bit mr, bit b);
        ins_t r;
        r.v = 1; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
        r.rd = rd; r.rw = rw; r.mr = mr; r.br = b;
        return r;
    endfunction

    function automatic ins_t at(int i);
        ins_t z = '{default: 0};
        if (i < inflight.size()) return inflight[i];
        return z;
    endfunction

    function automatic bit writes(ins_t r, int src);
        return r.v && r.rw && (r.rd != 0) && (r.rd == src);
    endfunction

    function automatic bit reads_result_of(ins_t r);
        return (cur_id.urs && writes(r, cur_id.rs)) || (cur_id.urt && writes(r, cur_id.rt));
    endfunction

    function automatic bit model_stall();
        if (FWD == 1) return at(0).mr && reads_result_of(at(0));
        return reads_result_of(at(0)) || reads_result_of(at(1)) || reads_result_of(at(2));
    endfunction

    function automatic int fwd_of(int src);
        if (writes(at(1), src)) return 2;
        if (writes(at(2), src)) return 1;
        return 0;
    endfunction

    task automatic drive_id(input ins_t i);
        cur_id   = i;
        id_rs    = 5'(i.rs);
        id_rt    = 5'(i.rt);
        id_rd    = 5'(i.rd);
        use_rs   = i.urs;
        use_rt   = i.urt;
        regwrite = i.rw;
        memread  = i.mr;
        br       = i.br;
    endtask

    task automatic check_outputs();
        int e_pc, e_ifid, e_fl, e_bub, e_exm, e_fa, e_fb;
        if (!m_valid) return;
        e_fa = 0;
        e_fb = 0;
        if (m_state == 0) begin
            e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1; e_exm = 0;
        end else if (mem_stall) begin
            e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 0; e_exm = 0;
        end else if (model_stall()) begin
            e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1; e_exm = 1;
        end else begin
            e_pc = 1; e_ifid = 1; e_fl = int'(cur_id.br); e_bub = 0; e_exm = 1;
        end
        if (FWD == 1 && m_state != 0) begin
            e_fa = fwd_of(at(0).rs);
            e_fb = fwd_of(at(0).rt);
        end
        chk("pc_write",     int'(pc_write_o),     e_pc);
        chk("if_id_write",  int'(if_id_write_o),  e_ifid);
        chk("if_id_flush",  int'(if_id_flush_o),  e_fl);
        chk("id_ex_bubble", int'(id_ex_bubble_o), e_bub);
        chk("ex_mem_write", int'(ex_mem_write_o), e_exm);
        chk("fwd_a",        int'(fwd_a_o),        e_fa);
        chk("fwd_b",        int'(fwd_b_o),        e_fb);
        chk("stall_cnt",    int'(stall_cnt_o),    m_cnt);
    endtask

    task automatic observe();
        cyc_n++;
        if (id_ex_bubble_o && ex_mem_write_o) begin obs_stalls++; last_stall = cyc_n; end
        if (if_id_flush_o) begin obs_flush++; flush_at = cyc_n; end
        if (fwd_a_o == 2'b01) seen_a01 = 1;
        if (fwd_a_o == 2'b10 && fwd_b_o == 2'b10) seen_ab10 = 1;
        if (fwd_a_o != 2'b00 || fwd_b_o != 2'b00) seen_fwd = 1;
    endtask

    task automatic enter(input ins_t i);
        inflight.push_front(i);
        if (inflight.size() > 3) void'(inflight.pop_back());
    endtask

    task automatic model_step();
        bit stall_now;
        m_adv = 0;
        if (rst) begin
            m_valid = 1;
            m_state = 0;
            m_cnt   = 0;
            inflight.delete();
        end else if (m_state == 0) begin
            if (start) m_state = 1;
        end else if (mem_stall) begin
            m_state = 2;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
            m_state   = 1;
            stall_now = model_stall();
            if (stall_now) begin
                enter('{default: 0});
                if (m_cnt < CNT_MAX) m_cnt++;
            end else begin
                enter(cur_id);
                m_adv = 1;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_outputs();
        observe();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_prog(input int n);
        int idx = 0;
        for (int c = 0; c < n; c++) begin
            if (idx < prog.size()) drive_id(prog[idx]);
            else drive_id(nop_i);
            cyc();
            if (m_adv) idx++;
        end
        drive_id(nop_i);
        prog.delete();
    endtask

    task automatic scenario_begin();
        rst = 1; cyc(); rst = 0;
        start = 1; cyc(); start = 0;
        cyc_n = 0; obs_stalls = 0; obs_flush = 0; last_stall = -100; flush_at = -200;
        seen_a01 = 0; seen_ab10 = 0; seen_fwd = 0;
    endtask

    initial begin
        nop_i = '{default: 0};
        rst = 1; start = 0; mem_stall = 0;
        drive_id(nop_i);
        cyc(); cyc();
        rst = 0;
        // Reset state, and mem_stall ignored while idle.
        mem_stall = 1; cyc(); cyc(); mem_stall = 0;
        chk("idle_cnt",    int'(stall_cnt_o),    0);
        chk("idle_pc",     int'(pc_write_o),     0);
        chk("idle_bubble", int'(id_ex_bubble_o), 1);
        start = 1; cyc(); start = 0;
        chk("run_pc",  int'(pc_write_o),  1);
        chk("run_cnt", int'(stall_cnt_o), 0);

        // lw $2 ; add $3,$2,$4
        scenario_begin();
        prog.push_back(mk(1, 0, 1, 0, 2, 1, 1, 0));
        prog.push_back(mk(2, 4, 1, 1, 3, 1, 0, 0));
        run_prog(8);
        chk("lu_stalls", obs_stalls, (FWD == 1) ? 1 : 3);
        chk("lu_cnt",    int'(stall_cnt_o), (FWD == 1) ? 1 : 3);
        chk("lu_fwd01",  int'(seen_a01), FWD);

        // add $2 ; sub $5,$2,$2
        scenario_begin();
        prog.push_back(mk(7, 8, 1, 1, 2, 1, 0, 0));
        prog.push_back(mk(2, 2, 1, 1, 5, 1, 0, 0));
        run_prog(8);
        chk("alu_stalls", obs_stalls, (FWD == 1) ? 0 : 3);
        chk("alu_fwd10",  int'(seen_ab10), FWD);

        // add $2 ; or $6,$2,$0
        scenario_begin();
        prog.push_back(mk(7, 8, 1, 1, 2, 1, 0, 0));
        prog.push_back(mk(2, 0, 1, 1, 6, 1, 0, 0));
        run_prog(8);
        chk("or_stalls", obs_stalls, (FWD == 1) ? 0 : 3);
        chk("or_cnt",    int'(stall_cnt_o), (FWD == 1) ? 0 : 3);
        chk("or_fwd",    int'(seen_fwd), FWD);

        // Taken branch with no hazard.
        scenario_begin();
        prog.push_back(nop_i);
        prog.push_back(mk(9, 9, 1, 1, 0, 0, 0, 1));
        run_prog(5);
        chk("br_flush",  obs_flush,  1);
        chk("br_stalls", obs_stalls, 0);

        // Taken branch depending on a load: flush follows the stall.
        scenario_begin();
        prog.push_back(mk(1, 0, 1, 0, 2, 1, 1, 0));
        prog.push_back(mk(2, 0, 1, 1, 0, 0, 0, 1));
        run_prog(8);
        chk("brlu_flush", obs_flush, 1);
        chk("brlu_delay", flush_at - last_stall, 1);

        // Memory freeze with a reset pulse in its third cycle.
        scenario_begin();
        run_prog(2);
        mem_stall = 1; cyc();
        chk("frz_exmem", int'(ex_mem_write_o), 0);
        chk("frz_pc",    int'(pc_write_o),     0);
        chk("frz_cnt",   int'(stall_cnt_o),    1);
        cyc();
        rst = 1; cyc(); rst = 0;
        chk("frz_rst_cnt",    int'(stall_cnt_o),    0);
        chk("frz_rst_bubble", int'(id_ex_bubble_o), 1);
        cyc(); mem_stall = 0; cyc();
        chk("frz_idle_cnt", int'(stall_cnt_o), 0);
        chk("frz_idle_pc",  int'(pc_write_o),  0);

        // Counter saturation; start_i held high while running.
        scenario_begin();
        start = 1; mem_stall = 1;
        repeat (10) cyc();
        chk("sat_cnt", int'(stall_cnt_o), CNT_MAX);
        mem_stall = 0; cyc();
        chk("sat_hold", int'(stall_cnt_o), CNT_MAX);
        start = 0; cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
